mcrom: RTL and testbench

Multi-channel synchronous ROM. One internal array is time-shared by CH_NUM requesters through a round-robin arbiter. Each channel gets its own registered read-data port and valid pulse. It replaces several single-port ROM instances where channels (e.g. per-correlator code or table lookups) read infrequently enough to share one array. Array content is initialised from another module, exactly as for the single-port ROM models.

---
 rtl/mcrom_if.sv | 29 ++
 rtl/mcrom.sv | 105 ++++++++++
 tb/tb_mcrom.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcrom_if.sv
// mcrom_if: request/grant/read-data bundle between the requesting channels
// and the shared multi-channel ROM.
interface mcrom_if #(
  parameter int unsigned CH_NUM     = 4,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [CH_NUM-1:0]            req;
  logic [CH_NUM*ADDR_WIDTH-1:0] addr;
  logic [CH_NUM-1:0]            ack;
  logic [CH_NUM-1:0]            rvalid;
  logic [CH_NUM*DATA_WIDTH-1:0] rdata;

  modport master (
    output req,
    output addr,
    input  ack,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ack,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/mcrom.sv
// mcrom: one synchronous ROM array time-shared by CH_NUM channels through a
// round-robin arbiter, with a registered data port and valid pulse per channel.
// Optional macro ROM_OUT_REG_EN inserts an output register stage (latency 2).
// Array contents are loaded by an outside module into mem, as for the
// single-port ROM models.
module mcrom #(
  parameter int unsigned ROM_SIZE   = 1024,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CH_NUM     = 4
) (
  input  logic   clk,
  input  logic   rst_b,
  mcrom_if.slave bus
);
  localparam int unsigned CH_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int unsigned IDX_W = (ROM_SIZE > 1) ? $clog2(ROM_SIZE) : 1;

  typedef struct packed {
    logic                  vld;
    logic [CH_W-1:0]       ch;
    logic [DATA_WIDTH-1:0] data;
  } rd_t;

  logic [DATA_WIDTH-1:0]        mem [0:ROM_SIZE-1];
  logic [CH_W-1:0]              last;
  logic [CH_NUM-1:0]            ack_c;
  logic                         gnt_vld_c;
  logic [CH_W-1:0]              gnt_ch_c;
  logic [ADDR_WIDTH-1:0]        gnt_addr_c;
  rd_t                          rd_c;
  rd_t                          out_c;
  logic [CH_NUM-1:0]            rvalid_q;
  logic [CH_NUM*DATA_WIDTH-1:0] rdata_q;

  // Round-robin scan beginning one past the last granted channel
  always_comb begin
    int unsigned idx;
    idx       = 0;
    ack_c     = '0;
    gnt_vld_c = 1'b0;
    gnt_ch_c  = '0;
    for (int unsigned k = 1; k <= CH_NUM; k++) begin
      idx = (32'(last) + k) % CH_NUM;
      if (!gnt_vld_c && rst_b && bus.req[CH_W'(idx)]) begin
        gnt_vld_c = 1'b1;
        gnt_ch_c  = CH_W'(idx);
      end
    end
    if (gnt_vld_c) ack_c[gnt_ch_c] = 1'b1;
  end

  // Granted address mux and array read; addresses past the array read as zero
  always_comb begin
    gnt_addr_c = bus.addr[32'(gnt_ch_c)*ADDR_WIDTH +: ADDR_WIDTH];
    rd_c       = '0;
    rd_c.vld   = gnt_vld_c;
    rd_c.ch    = gnt_ch_c;
    if (32'(gnt_addr_c) < ROM_SIZE) rd_c.data = mem[IDX_W'(gnt_addr_c)];
  end

  // Arbiter pointer moves only when something is granted
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      last <= CH_W'(CH_NUM - 1);
    end else if (gnt_vld_c) begin
      last <= gnt_ch_c;
    end
  end

`ifdef ROM_OUT_REG_EN
  rd_t rd_q;

  // Extra output stage; channel index and valid travel with the data
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_c;
    end
  end

  assign out_c = rd_q;
`else
  assign out_c = rd_c;
`endif

  // Per-channel result registers; only the served channel's slice changes
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= '0;
      if (out_c.vld) begin
        rvalid_q[out_c.ch] <= 1'b1;
        rdata_q[32'(out_c.ch)*DATA_WIDTH +: DATA_WIDTH] <= out_c.data;
      end
    end
  end

  assign bus.ack    = ack_c;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
endmodule

// File: tb/tb_mcrom.sv
// tb_mcrom: directed scenarios plus a randomized run of mcrom, checked against
// a behavioural model (round-robin pick + fixed-latency delay line).
module tb_mcrom;
  localparam int unsigned ROM_SIZE = 1000;
  localparam int unsigned AW       = 10;
  localparam int unsigned DW       = 32;
  localparam int unsigned CH       = 4;
  localparam int unsigned AW_ALL   = CH * AW;
`ifdef ROM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_b;
  int   checks   = 0;
  int   failures = 0;

  mcrom_if #(.CH_NUM(CH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mcrom #(.ROM_SIZE(ROM_SIZE), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CH_NUM(CH)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [DW-1:0]    ref_mem [0:ROM_SIZE-1];
  int               m_last;
  logic [CH-1:0]    m_rvalid;
  logic [CH*DW-1:0] m_rdata;
  logic             s_vld;
  int               s_ch;
  logic [DW-1:0]    s_data;

  function automatic int pick(input logic [CH-1:0] r, input int lst);
    for (int k = 1; k <= int'(CH); k++)
      if (r[(lst + k) % CH]) return (lst + k) % CH;
    return -1;
  endfunction

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    if (int'(a) < int'(ROM_SIZE)) return ref_mem[a];
    return '0;
  endfunction

  function automatic logic [CH-1:0] exp_ack();
    int g;
    g = pick(bus.req, m_last);
    if (rst_b !== 1'b1 || g < 0) return '0;
    return CH'(1) << g;
  endfunction

  always @(posedge clk or negedge rst_b) begin : model
    int            g;
    logic          o_vld;
    int            o_ch;
    logic [DW-1:0] o_data;
    logic [DW-1:0] e_data;
    if (!rst_b) begin
      m_last   <= CH - 1;
      m_rvalid <= '0;
      m_rdata  <= '0;
      s_vld    <= 1'b0;
      s_ch     <= 0;
      s_data   <= '0;
    end else begin
      g      = pick(bus.req, m_last);
      e_data = '0;
      if (g >= 0) e_data = rom_word(bus.addr[g*AW +: AW]);
`ifdef ROM_OUT_REG_EN
      o_vld  = s_vld;
      o_ch   = s_ch;
      o_data = s_data;
      s_vld  <= (g >= 0);
      s_ch   <= (g >= 0) ? g : 0;
      s_data <= e_data;
`else
      o_vld  = (g >= 0);
      o_ch   = (g >= 0) ? g : 0;
      o_data = e_data;
`endif
      if (g >= 0) m_last <= g;
      m_rvalid <= o_vld ? (CH'(1) << o_ch) : '0;
      if (o_vld) m_rdata[o_ch*DW +: DW] <= o_data;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_addr(input int ch, input logic [AW-1:0] a);
    bus.addr[ch*AW +: AW] = a;
  endtask

  task automatic do_reset();
    rst_b   = 1'b0;
    bus.req = '0;
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_b    = 1'b0;
    bus.req  = '1;
    bus.addr = AW_ALL'({$urandom, $urandom});
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++; if (bus.ack !== 4'b0000) begin failures++; $display("FAIL reset_ack: got %b expected 0000", bus.ack); end
    checks++; if (bus.rvalid !== 4'b0000) begin failures++; $display("FAIL reset_rvalid: got %b expected 0000", bus.rvalid); end
    checks++; if (bus.rdata !== '0) begin failures++; $display("FAIL reset_rdata: got %h expected 0", bus.rdata); end
    rst_b = 1'b1;
    #1;
    checks++; if (bus.ack !== 4'b0001) begin failures++; $display("FAIL reset_first_grant: got %b expected 0001", bus.ack); end
    bus.req = '0;
    @(negedge clk);
    #1;
    checks++; if (bus.rvalid !== 4'b0000) begin failures++; $display("FAIL reset_no_read: got %b expected 0000", bus.rvalid); end
  endtask

  task automatic test_single_read();
    logic [CH-1:0] ev;
    @(negedge clk);
    set_addr(2, 10'd5);
    bus.req = 4'b0100;
    #1;
    checks++; if (bus.ack !== 4'b0100) begin failures++; $display("FAIL single_ack: got %b expected 0100", bus.ack); end
    for (int d = 1; d <= LAT; d++) begin
      @(negedge clk);
      bus.req = '0;
      #1;
      ev = (d == LAT) ? 4'b0100 : 4'b0000;
      checks++; if (bus.rvalid !== ev) begin failures++; $display("FAIL single_rvalid d=%0d: got %b expected %b", d, bus.rvalid, ev); end
    end
    checks++; if (bus.rdata[95:64] !== 32'hDEADBEEF) begin failures++; $display("FAIL single_rdata: got %h expected deadbeef", bus.rdata[95:64]); end
    checks++; if ({bus.rdata[127:96], bus.rdata[63:0]} !== 96'h0) begin failures++; $display("FAIL single_others: got %h expected 0", {bus.rdata[127:96], bus.rdata[63:0]}); end
    @(negedge clk);
    #1;
    checks++; if (bus.rvalid !== 4'b0000) begin failures++; $display("FAIL single_pulse_end: got %b expected 0000", bus.rvalid); end
    checks++; if (bus.rdata[95:64] !== 32'hDEADBEEF) begin failures++; $display("FAIL single_hold: got %h expected deadbeef", bus.rdata[95:64]); end
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] ra [CH];
    int            cnt [CH];
    logic [CH-1:0] ea;
    do_reset();
    for (int ch = 0; ch < int'(CH); ch++) begin
      ra[ch]  = AW'($urandom_range(0, ROM_SIZE - 1));
      cnt[ch] = 0;
      set_addr(ch, ra[ch]);
    end
    for (int c = 0; c <= 7 + LAT; c++) begin
      @(negedge clk);
      bus.req = (c < 8) ? 4'b1111 : 4'b0000;
      #1;
      ea = (c < 8) ? (CH'(1) << (c % CH)) : 4'b0000;
      checks++; if (bus.ack !== ea) begin failures++; $display("FAIL rr_ack c=%0d: got %b expected %b", c, bus.ack, ea); end
      checks++; if (bus.rvalid !== m_rvalid) begin failures++; $display("FAIL rr_rvalid c=%0d: got %b expected %b", c, bus.rvalid, m_rvalid); end
      for (int ch = 0; ch < int'(CH); ch++) begin
        if (bus.rvalid[ch] === 1'b1) begin
          cnt[ch]++;
          checks++; if (bus.rdata[ch*DW +: DW] !== ref_mem[ra[ch]]) begin failures++; $display("FAIL rr_rdata ch%0d: got %h expected %h", ch, bus.rdata[ch*DW +: DW], ref_mem[ra[ch]]); end
        end
      end
    end
    for (int ch = 0; ch < int'(CH); ch++) begin
      checks++; if (cnt[ch] != 2) begin failures++; $display("FAIL rr_count ch%0d: got %0d expected 2", ch, cnt[ch]); end
    end
  endtask

  task automatic test_out_of_range();
    logic [AW-1:0] seq [4];
    logic [DW-1:0] ed;
    seq[0] = 10'd5;
    seq[1] = 10'd999;
    seq[2] = 10'd1000;
    seq[3] = 10'd1010;
    for (int c = 0; c <= 3 + LAT; c++) begin
      @(negedge clk);
      if (c < 4) begin
        bus.req = 4'b0001;
        set_addr(0, seq[c]);
      end else begin
        bus.req = 4'b0000;
      end
      #1;
      if (c < 4) begin
        checks++; if (bus.ack !== 4'b0001) begin failures++; $display("FAIL oor_ack c=%0d: got %b expected 0001", c, bus.ack); end
      end
      if (c >= LAT) begin
        ed = (int'(seq[c-LAT]) < int'(ROM_SIZE)) ? ref_mem[seq[c-LAT]] : 32'h0;
        checks++; if (bus.rvalid !== 4'b0001) begin failures++; $display("FAIL oor_rvalid c=%0d: got %b expected 0001", c, bus.rvalid); end
        checks++; if (bus.rdata[31:0] !== ed) begin failures++; $display("FAIL oor_rdata addr=%0d: got %h expected %h", seq[c-LAT], bus.rdata[31:0], ed); end
      end else begin
        checks++; if (bus.rvalid !== 4'b0000) begin failures++; $display("FAIL oor_idle c=%0d: got %b expected 0000", c, bus.rvalid); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [CH-1:0] ev;
    for (int c = 0; c <= LAT + 2; c++) begin
      @(negedge clk);
      if (c < 2) begin
        bus.req = 4'b0010;
        set_addr(1, AW'(3 + c));
      end else begin
        bus.req = 4'b0000;
      end
      #1;
      ev = (c >= LAT && c < LAT + 2) ? 4'b0010 : 4'b0000;
      checks++; if (bus.rvalid !== ev) begin failures++; $display("FAIL b2b_rvalid c=%0d: got %b expected %b", c, bus.rvalid, ev); end
      if (c >= LAT && c < LAT + 2) begin
        checks++; if (bus.rdata[63:32] !== ref_mem[3 + c - LAT]) begin failures++; $display("FAIL b2b_rdata c=%0d: got %h expected %h", c, bus.rdata[63:32], ref_mem[3 + c - LAT]); end
      end
    end
    checks++; if (bus.rdata[63:32] !== ref_mem[4]) begin failures++; $display("FAIL b2b_hold: got %h expected %h", bus.rdata[63:32], ref_mem[4]); end
  endtask

  task automatic test_midflight_reset();
    @(negedge clk);
    set_addr(3, 10'd7);
    bus.req = 4'b1000;
    #1;
    checks++; if (bus.ack !== 4'b1000) begin failures++; $display("FAIL mid_ack: got %b expected 1000", bus.ack); end
    @(posedge clk);
    #1;
    rst_b   = 1'b0;
    bus.req = 4'b1111;
    @(negedge clk);
    #1;
    checks++; if (bus.rvalid !== 4'b0000) begin failures++; $display("FAIL mid_rvalid_in_reset: got %b expected 0000", bus.rvalid); end
    checks++; if (bus.ack !== 4'b0000) begin failures++; $display("FAIL mid_ack_in_reset: got %b expected 0000", bus.ack); end
    bus.req = '0;
    rst_b   = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      checks++; if (bus.rvalid !== 4'b0000) begin failures++; $display("FAIL mid_no_rvalid c=%0d: got %b expected 0000", c, bus.rvalid); end
    end
    bus.req = 4'b1111;
    #1;
    checks++; if (bus.ack !== 4'b0001) begin failures++; $display("FAIL mid_restart: got %b expected 0001", bus.ack); end
    bus.req = '0;
  endtask

  task automatic test_random();
    logic [CH-1:0] ea;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      bus.req  = CH'($urandom);
      bus.addr = AW_ALL'({$urandom, $urandom});
      #1;
      ea = exp_ack();
      checks++; if (bus.ack !== ea) begin failures++; $display("FAIL rand_ack c=%0d: got %b expected %b", c, bus.ack, ea); end
      checks++; if (bus.rvalid !== m_rvalid) begin failures++; $display("FAIL rand_rvalid c=%0d: got %b expected %b", c, bus.rvalid, m_rvalid); end
      checks++; if (bus.rdata !== m_rdata) begin failures++; $display("FAIL rand_rdata c=%0d: got %h expected %h", c, bus.rdata, m_rdata); end
    end
    @(negedge clk);
    bus.req = '0;
  endtask

  initial begin
    rst_b    = 1'b0;
    bus.req  = '0;
    bus.addr = '0;
    for (int i = 0; i < int'(ROM_SIZE); i++) begin
      ref_mem[i] = $urandom | 32'h1;
      dut.mem[i] = ref_mem[i];
    end
    ref_mem[5] = 32'hDEADBEEF;
    dut.mem[5] = 32'hDEADBEEF;

    test_reset();
    test_single_read();
    test_round_robin();
    test_out_of_range();
    test_back_to_back();
    test_midflight_reset();
    test_random();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: time limit reached at %0t, expected completion earlier", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
